// File: rtl/jk_exc_pkg.sv
// Shared types and constants for the JK excitation driver: FSM states,
// don't-care policy encodings and counter widths.
package jk_exc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam bit DC_HOLD   = 1'b0;
  localparam bit DC_TOGGLE = 1'b1;

  localparam int ERR_CNT_W = 8;
  localparam int RETRY_W   = 3;

endpackage

// File: rtl/jk_excite_lut.sv
// Combinational inverse of a JK flop: from current q and wanted t, produce
// the J/K pair that moves q to t, filling don't-cares with DC_POLICY.
module jk_excite_lut
  import jk_exc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit DC_POLICY = DC_HOLD
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  localparam logic [WIDTH-1:0] DC_VEC = {WIDTH{DC_POLICY}};

  // J only matters when q=0, K only matters when q=1.
  assign j = (~q & t)  | (q  & DC_VEC);
  assign k = (q  & ~t) | (~q & DC_VEC);

endmodule

// File: rtl/jk_excitation_driver.sv
// Accepts a target word, drives one cycle of J/K excitation into a posedge JK
// bank, then checks the bank's feedback and retries or reports done/err.
module jk_excitation_driver
  import jk_exc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit DC_POLICY = DC_HOLD,
  parameter int MAX_RETRY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  input  logic [WIDTH-1:0]     tgt_data,
  output logic [WIDTH-1:0]     j,
  output logic [WIDTH-1:0]     k,
  input  logic [WIDTH-1:0]     q_fb,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_t               state;
  logic [WIDTH-1:0]     tgt_q;
  logic [RETRY_W-1:0]   retry;
  logic [WIDTH-1:0]     lut_t;
  logic [WIDTH-1:0]     lut_j;
  logic [WIDTH-1:0]     lut_k;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

  // In IDLE the excitation is computed from the incoming word; on retries
  // it comes from the latched target.
  assign lut_t = (state == IDLE) ? tgt_data : tgt_q;

  jk_excite_lut #(
    .WIDTH    (WIDTH),
    .DC_POLICY(DC_POLICY)
  ) u_lut (
    .q(q_fb),
    .t(lut_t),
    .j(lut_j),
    .k(lut_k)
  );

  assign tgt_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tgt_q   <= '0;
      retry   <= '0;
      j       <= '0;
      k       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_q <= tgt_data;
            j     <= lut_j;
            k     <= lut_k;
            retry <= '0;
            busy  <= 1'b1;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          j     <= '0;
          k     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == tgt_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (retry != RETRY_LIM) begin
            retry <= retry + RETRY_W'(1);
            j     <= lut_j;
            k     <= lut_k;
            state <= DRIVE;
          end else begin
            err     <= 1'b1;
            err_cnt <= sat_inc(err_cnt);
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: two drivers (hold and toggle don't-care policy) each steer
// their own behavioural JK bank; expectations come from the excitation table.
module tb_jk_excitation_driver;
  import jk_exc_pkg::*;

  localparam int W   = 4;
  localparam int MR  = 1;
  localparam int TMO = 64;

  typedef struct {
    logic [W-1:0] tgt;
    logic [W-1:0] fin;
    logic [W-1:0] j0;
    logic [W-1:0] k0;
    logic [W-1:0] j1;
    logic [W-1:0] k1;
    bit           is_err;
    int           acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, tgt_valid, bank_load;
  logic [W-1:0] tgt_data, stuck, bank_init, bank0, bank1;
  logic [W-1:0] j0, k0, j1, k1;
  logic         rdy0, rdy1, busy0, busy1, done0, done1, err0, err1;
  logic [7:0]   ec0, ec1;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_err = 0;
  exp_t sb[$];
  exp_t pe;

  jk_excitation_driver #(.WIDTH(W), .DC_POLICY(DC_HOLD), .MAX_RETRY(MR)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
    .tgt_data(tgt_data), .j(j0), .k(k0), .q_fb(bank0),
    .busy(busy0), .done(done0), .err(err0), .err_cnt(ec0)
  );

  jk_excitation_driver #(.WIDTH(W), .DC_POLICY(DC_TOGGLE), .MAX_RETRY(MR)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
    .tgt_data(tgt_data), .j(j1), .k(k1), .q_fb(bank1),
    .busy(busy1), .done(done1), .err(err1), .err_cnt(ec1)
  );

  // Behavioural posedge JK banks; bits set in 'stuck' are forced to 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bank_load) begin
      bank0 <= bank_init;
      bank1 <= bank_init;
    end else begin
      bank0 <= ((j0 & ~bank0) | (~k0 & bank0)) & ~stuck;
      bank1 <= ((j1 & ~bank1) | (~k1 & bank1)) & ~stuck;
    end
  end

  function automatic void exc(input logic [W-1:0] q, input logic [W-1:0] t, input bit dc,
                              output logic [W-1:0] jj, output logic [W-1:0] kk);
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b00:   begin jj[i] = 1'b0; kk[i] = dc;   end
        2'b01:   begin jj[i] = 1'b1; kk[i] = dc;   end
        2'b10:   begin jj[i] = dc;   kk[i] = 1'b1; end
        default: begin jj[i] = dc;   kk[i] = 1'b0; end
      endcase
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push side: record the expected response at every accepting edge.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
    end else if (tgt_valid && rdy0) begin
      pe.tgt    = tgt_data;
      pe.fin    = tgt_data & ~stuck;
      pe.is_err = (pe.fin != tgt_data);
      exc(bank0, tgt_data, 1'b0, pe.j0, pe.k0);
      exc(bank1, tgt_data, 1'b1, pe.j1, pe.k1);
      pe.acc_cyc = cyc + 1;
      sb.push_back(pe);
    end
  end

  // Monitor side: compare whenever the DUTs start driving or report a result.
  initial begin
    logic bp;
    logic r;
    exp_t e;
    bp = 1'b0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        bp = 1'b0;
        model_err = 0;
        continue;
      end
      chk("ready_while_busy0", busy0 & rdy0, 0);
      chk("ready_while_busy1", busy1 & rdy1, 0);
      chk("done_and_err0", done0 & err0, 0);
      chk("done_and_err1", done1 & err1, 0);
      if (!busy0) chk("idle_jk", {j0, k0, j1, k1}, 0);
      if (busy0 && !bp) begin
        if (sb.size() == 0) begin
          chk("drive_without_accept", 1, 0);
        end else begin
          chk("first_j0", j0, sb[0].j0);
          chk("first_k0", k0, sb[0].k0);
          chk("first_j1", j1, sb[0].j1);
          chk("first_k1", k1, sb[0].k1);
        end
      end
      bp = busy0;
      if (done0 | err0 | done1 | err1) begin
        if (sb.size() == 0) begin
          chk("result_without_accept", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done0", done0, !e.is_err);
          chk("err0", err0, e.is_err);
          chk("done1", done1, !e.is_err);
          chk("err1", err1, e.is_err);
          chk("latency", cyc - e.acc_cyc, e.is_err ? 2 * (MR + 1) : 2);
          chk("bank0", bank0, e.fin);
          chk("bank1", bank1, e.fin);
          if (e.is_err && model_err < 255) model_err++;
          chk("err_cnt0", ec0, model_err);
          chk("err_cnt1", ec1, model_err);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(rdy0 && !busy0) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("idle_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d);
    int n = 0;
    tgt_valid = 1'b1;
    tgt_data  = d;
    while (!rdy0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("accept_timeout", n, 0);
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_data  = W'($urandom);
  endtask

  task automatic load(input logic [W-1:0] v);
    bank_init = v;
    bank_load = 1'b1;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  task automatic stream(input int ncyc);
    tgt_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      tgt_data = W'($urandom);
      @(negedge clk);
    end
    tgt_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0; stuck = '0;
    bank_load = 1'b1; bank_init = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_jk", {j0, k0, j1, k1}, 0);
    chk("rst_done_err", {done0, err0, done1, err1}, 0);
    chk("rst_err_cnt", ec0, 0);
    rst = 1'b0;
    @(negedge clk);
    bank_load = 1'b0;

    // bank 0000 -> 1010, then 1100 -> 0110, then a stuck bit forcing err
    send(4'b1010);
    wait_idle();
    load(4'b1100);
    send(4'b0110);
    wait_idle();
    stuck = 4'b0001;
    send(4'b0001);
    wait_idle();
    stuck = '0;

    // tgt_valid held high with data changing every cycle
    stream(60);
    stuck = W'($urandom_range(1, 15));
    stream(60);
    stuck = '0;
    load(W'($urandom));
    stream(40);

    // gapped random traffic
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(W'($urandom));
    end
    wait_idle();

    // reset while in DRIVE
    stuck = 4'b1000;
    send(4'b1000);
    wait_idle();
    stuck = '0;
    tgt_valid = 1'b1;
    tgt_data  = ~bank0;
    @(negedge clk);
    tgt_valid = 1'b0;
    chk("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_jk", {j0, k0, j1, k1}, 0);
    chk("mid_rst_busy", {busy0, busy1}, 0);
    chk("mid_rst_done_err", {done0, err0, done1, err1}, 0);
    chk("mid_rst_err_cnt", {ec0, ec1}, 0);
    chk("mid_rst_ready", {rdy0, rdy1}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 256 forced failures saturate err_cnt
    stuck = 4'b1111;
    for (int i = 0; i < 256; i++) begin
      send(W'($urandom_range(1, 15)));
      wait_idle();
    end
    stuck = '0;
    chk("sat_err_cnt0", ec0, 255);
    chk("sat_err_cnt1", ec1, 255);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
